// File: rtl/uart_serial_core.sv
// UART transceiver: 16x-oversampling tick generator shared by an RX deserialiser
// (valid/ready source with error/overrun pulses) and a TX serialiser (valid/ready sink).
module uart_serial_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_uart,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 tx_uart,
    input  logic [DATA_BITS-1:0] tx_byte,
    input  logic                 tx_valid,
    output logic                 tx_ready
);

    localparam int RAW_DIV_C = CLK_HZ / (BAUD * 16);
    localparam int DIV_C     = (RAW_DIV_C < 1) ? 1 : RAW_DIV_C;
    localparam int DIV_W_C   = (DIV_C > 1) ? $clog2(DIV_C) : 1;
    localparam logic [DIV_W_C-1:0] DIV_LAST_C = DIV_W_C'(DIV_C - 1);
    localparam logic [3:0] LAST_BIT_C  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP_C = 1'(STOP_BITS - 1);
    localparam logic [3:0] MID_C = 4'd7;
    localparam logic [3:0] END_C = 4'd15;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Parity bit that makes the frame odd (PARITY=1) or even (PARITY=2).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) parity_bit = ~(^d);
        else             parity_bit = ^d;
    endfunction

    logic [DIV_W_C-1:0] div_cnt_r;
    logic               tick_s;
    logic               rx_meta_r, rx_s_r;

    state_t                rx_state_r, rx_state_n;
    logic [3:0]            rx_cnt_r, rx_cnt_n, rx_bits_r, rx_bits_n;
    logic [DATA_BITS-1:0]  rx_shift_r, rx_shift_n, rx_byte_r, rx_byte_n;
    logic                  rx_par_r, rx_par_n, rx_valid_r, rx_valid_n;
    logic                  ferr_r, ferr_n, perr_r, perr_n, ovr_r, ovr_n;

    state_t                tx_state_r, tx_state_n;
    logic [3:0]            tx_cnt_r, tx_cnt_n, tx_bits_r, tx_bits_n;
    logic [DATA_BITS-1:0]  tx_shift_r, tx_shift_n;
    logic                  tx_par_r, tx_par_n, tx_armed_r, tx_armed_n;
    logic                  tx_stop_r, tx_stop_n, tx_uart_r, tx_uart_n, tx_ready_r, tx_ready_n;

    assign tick_s = (div_cnt_r == DIV_LAST_C);

    // Free-running oversampling divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              div_cnt_r <= '0;
        else if (tick_s)         div_cnt_r <= '0;
        else                     div_cnt_r <= div_cnt_r + DIV_W_C'(1);
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx_uart;
            rx_s_r    <= rx_meta_r;
        end
    end

    // RX next-state, sampling, frame outcome and handshake.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_cnt_n   = rx_cnt_r;
        rx_bits_n  = rx_bits_r;
        rx_shift_n = rx_shift_r;
        rx_par_n   = rx_par_r;
        rx_byte_n  = rx_byte_r;
        ferr_n     = 1'b0;
        perr_n     = 1'b0;
        ovr_n      = 1'b0;
        if (rx_valid_r && rx_ready) rx_valid_n = 1'b0;
        else                        rx_valid_n = rx_valid_r;
        case (rx_state_r)
            ST_IDLE: begin
                if (tick_s && !rx_s_r) begin
                    rx_state_n = ST_START;
                    rx_cnt_n   = 4'd0;
                end else begin
                    rx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (!tick_s)                 rx_cnt_n = rx_cnt_r;
                else if (rx_cnt_r != MID_C)  rx_cnt_n = rx_cnt_r + 4'd1;
                else if (!rx_s_r) begin
                    rx_state_n = ST_DATA;
                    rx_cnt_n   = 4'd0;
                    rx_bits_n  = 4'd0;
                end else begin
                    rx_state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!tick_s)                 rx_cnt_n = rx_cnt_r;
                else if (rx_cnt_r != END_C)  rx_cnt_n = rx_cnt_r + 4'd1;
                else begin
                    rx_cnt_n   = 4'd0;
                    rx_bits_n  = rx_bits_r + 4'd1;
                    rx_shift_n = {rx_s_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bits_r != LAST_BIT_C) rx_state_n = ST_DATA;
                    else if (PARITY != 0)        rx_state_n = ST_PARITY;
                    else                         rx_state_n = ST_STOP;
                end
            end
            ST_PARITY: begin
                if (!tick_s)                 rx_cnt_n = rx_cnt_r;
                else if (rx_cnt_r != END_C)  rx_cnt_n = rx_cnt_r + 4'd1;
                else begin
                    rx_cnt_n   = 4'd0;
                    rx_par_n   = rx_s_r;
                    rx_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!tick_s)                 rx_cnt_n = rx_cnt_r;
                else if (rx_cnt_r != END_C)  rx_cnt_n = rx_cnt_r + 4'd1;
                else begin
                    // Frame error outranks parity; a same-cycle transfer frees the slot.
                    rx_cnt_n   = 4'd0;
                    rx_state_n = ST_IDLE;
                    if (!rx_s_r)                                              ferr_n = 1'b1;
                    else if ((PARITY != 0) && (rx_par_r != parity_bit(rx_shift_r))) perr_n = 1'b1;
                    else if (rx_valid_r && !rx_ready)                         ovr_n  = 1'b1;
                    else begin
                        rx_byte_n  = rx_shift_r;
                        rx_valid_n = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
                rx_cnt_n   = 4'd0;
            end
        endcase
    end

    // RX state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= 4'd0;
            rx_bits_r  <= 4'd0;
            rx_shift_r <= '0;
            rx_par_r   <= 1'b0;
            rx_byte_r  <= '0;
            rx_valid_r <= 1'b0;
            ferr_r     <= 1'b0;
            perr_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bits_r  <= rx_bits_n;
            rx_shift_r <= rx_shift_n;
            rx_par_r   <= rx_par_n;
            rx_byte_r  <= rx_byte_n;
            rx_valid_r <= rx_valid_n;
            ferr_r     <= ferr_n;
            perr_r     <= perr_n;
            ovr_r      <= ovr_n;
        end
    end

    // TX next-state and line value; the start bit waits for the first tick after acceptance.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bits_n  = tx_bits_r;
        tx_shift_n = tx_shift_r;
        tx_par_n   = tx_par_r;
        tx_armed_n = tx_armed_r;
        tx_stop_n  = tx_stop_r;
        tx_uart_n  = tx_uart_r;
        case (tx_state_r)
            ST_IDLE: begin
                tx_uart_n = 1'b1;
                if (tx_valid && tx_ready_r) begin
                    tx_state_n = ST_START;
                    tx_shift_n = tx_byte;
                    tx_par_n   = parity_bit(tx_byte);
                    tx_armed_n = 1'b0;
                end else begin
                    tx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (!tick_s)                 tx_cnt_n = tx_cnt_r;
                else if (!tx_armed_r) begin
                    tx_uart_n  = 1'b0;
                    tx_armed_n = 1'b1;
                    tx_cnt_n   = 4'd0;
                end else if (tx_cnt_r != END_C) tx_cnt_n = tx_cnt_r + 4'd1;
                else begin
                    tx_state_n = ST_DATA;
                    tx_uart_n  = tx_shift_r[0];
                    tx_bits_n  = 4'd0;
                    tx_cnt_n   = 4'd0;
                end
            end
            ST_DATA: begin
                if (!tick_s)                 tx_cnt_n = tx_cnt_r;
                else if (tx_cnt_r != END_C)  tx_cnt_n = tx_cnt_r + 4'd1;
                else begin
                    tx_cnt_n = 4'd0;
                    if (tx_bits_r != LAST_BIT_C) begin
                        tx_bits_n  = tx_bits_r + 4'd1;
                        tx_uart_n  = tx_shift_r[1];
                        tx_shift_n = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                    end else if (PARITY != 0) begin
                        tx_state_n = ST_PARITY;
                        tx_uart_n  = tx_par_r;
                    end else begin
                        tx_state_n = ST_STOP;
                        tx_uart_n  = 1'b1;
                        tx_stop_n  = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (!tick_s)                 tx_cnt_n = tx_cnt_r;
                else if (tx_cnt_r != END_C)  tx_cnt_n = tx_cnt_r + 4'd1;
                else begin
                    tx_state_n = ST_STOP;
                    tx_uart_n  = 1'b1;
                    tx_stop_n  = 1'b0;
                    tx_cnt_n   = 4'd0;
                end
            end
            ST_STOP: begin
                if (!tick_s)                      tx_cnt_n = tx_cnt_r;
                else if (tx_cnt_r != END_C)       tx_cnt_n = tx_cnt_r + 4'd1;
                else if (tx_stop_r == LAST_STOP_C) begin
                    tx_state_n = ST_IDLE;
                    tx_cnt_n   = 4'd0;
                end else begin
                    tx_stop_n = tx_stop_r + 1'b1;
                    tx_cnt_n  = 4'd0;
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_uart_n  = 1'b1;
            end
        endcase
        tx_ready_n = (tx_state_n == ST_IDLE);
    end

    // TX state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 4'd0;
            tx_bits_r  <= 4'd0;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_armed_r <= 1'b0;
            tx_stop_r  <= 1'b0;
            tx_uart_r  <= 1'b1;
            tx_ready_r <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bits_r  <= tx_bits_n;
            tx_shift_r <= tx_shift_n;
            tx_par_r   <= tx_par_n;
            tx_armed_r <= tx_armed_n;
            tx_stop_r  <= tx_stop_n;
            tx_uart_r  <= tx_uart_n;
            tx_ready_r <= tx_ready_n;
        end
    end

    assign rx_byte       = rx_byte_r;
    assign rx_valid      = rx_valid_r;
    assign rx_frame_err  = ferr_r;
    assign rx_parity_err = perr_r;
    assign rx_overrun    = ovr_r;
    assign tx_uart       = tx_uart_r;
    assign tx_ready      = tx_ready_r;

endmodule

// File: tb/tb_uart_serial_core.sv
// Directed bench for uart_serial_core: four instances (8N1, 8E2 loopback, 8O1, 7N1 loopback)
// at one tick per clock, driven from vector tables plus hand-written corner sequences.
module tb_uart_serial_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: 8N1, bench-driven RX
    logic rx_a = 1'b1, rx_ready_a = 1'b1, tx_valid_a = 1'b0, tx_a, tx_ready_a;
    logic rx_valid_a, ferr_a_s, perr_a_s, ovr_a_s;
    logic [7:0] rx_byte_a, tx_byte_a = 8'h00;
    // b: 8E2 loopback
    logic tx_b, tx_ready_b, tx_valid_b = 1'b0, rx_valid_b, ferr_b_s, perr_b_s, ovr_b_s;
    logic [7:0] rx_byte_b, tx_byte_b = 8'h00;
    // c: 8O1, bench-driven RX
    logic rx_c = 1'b1, tx_c, tx_ready_c, rx_valid_c, ferr_c_s, perr_c_s, ovr_c_s;
    logic [7:0] rx_byte_c;
    // d: 7N1 loopback
    logic tx_d, tx_ready_d, tx_valid_d = 1'b0, rx_valid_d, ferr_d_s, perr_d_s, ovr_d_s;
    logic [6:0] rx_byte_d, tx_byte_d = 7'h00;

    uart_serial_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_uart(rx_a), .rx_byte(rx_byte_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .rx_frame_err(ferr_a_s), .rx_parity_err(perr_a_s), .rx_overrun(ovr_a_s),
        .tx_uart(tx_a), .tx_byte(tx_byte_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a));
    uart_serial_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_uart(tx_b), .rx_byte(rx_byte_b), .rx_valid(rx_valid_b),
        .rx_ready(1'b1), .rx_frame_err(ferr_b_s), .rx_parity_err(perr_b_s), .rx_overrun(ovr_b_s),
        .tx_uart(tx_b), .tx_byte(tx_byte_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b));
    uart_serial_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .rx_uart(rx_c), .rx_byte(rx_byte_c), .rx_valid(rx_valid_c),
        .rx_ready(1'b1), .rx_frame_err(ferr_c_s), .rx_parity_err(perr_c_s), .rx_overrun(ovr_c_s),
        .tx_uart(tx_c), .tx_byte(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready_c));
    uart_serial_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_d (
        .clk(clk), .rst_n(rst_n), .rx_uart(tx_d), .rx_byte(rx_byte_d), .rx_valid(rx_valid_d),
        .rx_ready(1'b1), .rx_frame_err(ferr_d_s), .rx_parity_err(perr_d_s), .rx_overrun(ovr_d_s),
        .tx_uart(tx_d), .tx_byte(tx_byte_d), .tx_valid(tx_valid_d), .tx_ready(tx_ready_d));

    int n_checks = 0;
    int n_fail = 0;

    // Event counters observed on the falling edge.
    int vr_a = 0, ovr_a = 0, err_a = 0;
    int rcv_b = 0, err_b = 0, rcv_d = 0, err_d = 0;
    int vr_c = 0, ferr_c = 0, perr_c = 0, ovr_c = 0;
    logic prev_va = 1'b0, prev_vc = 1'b0;
    logic [7:0] last_b = 8'h00, last_c = 8'h00;
    logic [6:0] last_d = 7'h00;

    always @(negedge clk) begin
        prev_va <= rx_valid_a;
        prev_vc <= rx_valid_c;
        if (rx_valid_a && !prev_va) vr_a <= vr_a + 1;
        if (ovr_a_s) ovr_a <= ovr_a + 1;
        if (ferr_a_s || perr_a_s) err_a <= err_a + 1;
        if (rx_valid_b) begin rcv_b <= rcv_b + 1; last_b <= rx_byte_b; end
        if (ferr_b_s || perr_b_s || ovr_b_s) err_b <= err_b + 1;
        if (rx_valid_d) begin rcv_d <= rcv_d + 1; last_d <= rx_byte_d; end
        if (ferr_d_s || perr_d_s || ovr_d_s) err_d <= err_d + 1;
        if (rx_valid_c && !prev_vc) begin vr_c <= vr_c + 1; last_c <= rx_byte_c; end
        if (ferr_c_s) ferr_c <= ferr_c + 1;
        if (perr_c_s) perr_c <= perr_c + 1;
        if (ovr_c_s) ovr_c <= ovr_c + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0: get_tx = tx_a;
            1: get_tx = tx_b;
            default: get_tx = tx_d;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: get_ready = tx_ready_a;
            1: get_ready = tx_ready_b;
            default: get_ready = tx_ready_d;
        endcase
    endfunction

    task automatic drive_tx(input int sel, input logic [7:0] d, input logic v);
        case (sel)
            0: begin tx_byte_a = d; tx_valid_a = v; end
            1: begin tx_byte_b = d; tx_valid_b = v; end
            default: begin tx_byte_d = d[6:0]; tx_valid_d = v; end
        endcase
    endtask

    // line: bit i is the expected line level during bit-time i of the frame
    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [11:0] line;
        int          nbits;
        int          len;
    } tx_vec_t;

    typedef struct {
        int          sel;
        logic [11:0] bits;
        int          nbits;
        int          d_ferr;
        int          d_perr;
        int          d_valid;
        logic [7:0]  exp_byte;
    } rx_vec_t;

    task automatic tx_check(input tx_vec_t v);
        int n;
        logic ready_low;
        n = 0;
        while (!get_ready(v.sel) && n < 400) begin @(negedge clk); n++; end
        chk("tx_ready_idle", 32'(get_ready(v.sel)), 32'd1);
        drive_tx(v.sel, v.data, 1'b1);
        @(negedge clk);
        drive_tx(v.sel, v.data, 1'b0);
        n = 0;
        while (get_tx(v.sel) && n < 8) begin @(negedge clk); n++; end
        chk("tx_start_edge", 32'(get_tx(v.sel)), 32'd0);
        ready_low = 1'b1;
        repeat (8) @(negedge clk);
        n = 8;
        for (int i = 0; i < v.nbits; i++) begin
            chk($sformatf("tx_bit%0d_%0h", i, v.data), 32'(get_tx(v.sel)), 32'(v.line[i]));
            if (get_ready(v.sel)) ready_low = 1'b0;
            if (i < v.nbits - 1) begin
                repeat (16) @(negedge clk);
                n += 16;
            end
        end
        chk("tx_ready_low_in_frame", 32'(ready_low), 32'd1);
        while (!get_ready(v.sel) && n < 400) begin @(negedge clk); n++; end
        chk("tx_frame_len", 32'(n), 32'(v.len));
    endtask

    task automatic send_rx(input int sel, input logic [11:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) rx_a = bits[i];
            else          rx_c = bits[i];
            repeat (16) @(negedge clk);
        end
        rx_a = 1'b1;
        rx_c = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    tx_vec_t txv[7];
    rx_vec_t rxv[5];

    initial begin
        int b0, f0, p0, v0, e0;
        // Hand-computed line images {stop(s), parity, data LSB-first, start}
        txv[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 160};
        txv[1] = '{0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 160};
        txv[2] = '{1, 8'h00, {2'b11, 1'b0, 8'h00, 1'b0}, 12, 192};
        txv[3] = '{1, 8'hFF, {2'b11, 1'b0, 8'hFF, 1'b0}, 12, 192};
        txv[4] = '{1, 8'h3C, {2'b11, 1'b0, 8'h3C, 1'b0}, 12, 192};
        txv[5] = '{3, 8'h7F, {3'b000, 1'b1, 7'h7F, 1'b0}, 9, 144};
        txv[6] = '{0, 8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 160};
        // 8O1 frames {stop, parity, data, start}
        rxv[0] = '{1, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 0, 0, 1, 8'h01};
        rxv[1] = '{1, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, 1, 0, 8'h00};
        rxv[2] = '{1, {1'b0, 1'b0, 1'b0, 8'h01, 1'b0}, 11, 1, 0, 0, 8'h00};
        rxv[3] = '{1, {1'b0, 1'b0, 1'b1, 8'h01, 1'b0}, 11, 1, 0, 0, 8'h00};
        rxv[4] = '{1, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 0, 0, 1, 8'h03};

        repeat (3) @(negedge clk);
        chk("rst_tx_uart", 32'(tx_a), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        chk("rst_rx_byte", 32'(rx_byte_a), 32'd0);
        chk("rst_err_pulses", 32'({ferr_a_s, perr_a_s, ovr_a_s}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            b0 = (txv[k].sel == 1) ? rcv_b : rcv_d;
            tx_check(txv[k]);
            repeat (4) @(negedge clk);
            if (txv[k].sel == 1) begin
                chk("loop_8e2_count", 32'(rcv_b), 32'(b0 + 1));
                chk("loop_8e2_byte", 32'(last_b), 32'(txv[k].data));
                chk("loop_8e2_errs", 32'(err_b), 32'd0);
            end else if (txv[k].sel == 3) begin
                chk("loop_7n1_count", 32'(rcv_d), 32'(b0 + 1));
                chk("loop_7n1_byte", 32'(last_d), 32'(txv[k].data[6:0]));
                chk("loop_7n1_errs", 32'(err_d), 32'd0);
            end
        end

        for (int k = 0; k < 5; k++) begin
            f0 = ferr_c; p0 = perr_c; v0 = vr_c;
            send_rx(rxv[k].sel, rxv[k].bits, rxv[k].nbits);
            chk($sformatf("rx8o1_%0d_ferr", k), 32'(ferr_c - f0), 32'(rxv[k].d_ferr));
            chk($sformatf("rx8o1_%0d_perr", k), 32'(perr_c - p0), 32'(rxv[k].d_perr));
            chk($sformatf("rx8o1_%0d_valid", k), 32'(vr_c - v0), 32'(rxv[k].d_valid));
            if (rxv[k].d_valid != 0)
                chk($sformatf("rx8o1_%0d_byte", k), 32'(last_c), 32'(rxv[k].exp_byte));
        end
        chk("rx8o1_no_overrun", 32'(ovr_c), 32'd0);

        // Overrun with consumer stalled
        rx_ready_a = 1'b0;
        send_rx(0, {2'b00, 1'b1, 8'h11, 1'b0}, 10);
        chk("ovr_first_valid", 32'(rx_valid_a), 32'd1);
        chk("ovr_first_byte", 32'(rx_byte_a), 32'h11);
        send_rx(0, {2'b00, 1'b1, 8'h22, 1'b0}, 10);
        chk("ovr_pulse_count", 32'(ovr_a), 32'd1);
        chk("ovr_byte_held", 32'(rx_byte_a), 32'h11);
        chk("ovr_valid_held", 32'(rx_valid_a), 32'd1);
        rx_ready_a = 1'b1;
        @(negedge clk);
        chk("ovr_transfer_valid_low", 32'(rx_valid_a), 32'd0);

        // Short low glitch is a false start
        v0 = vr_a; e0 = err_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_valid", 32'(vr_a), 32'(v0));
        chk("glitch_no_err", 32'(err_a), 32'(e0));

        // Reset mid TX frame, then a clean frame
        drive_tx(0, 8'h5A, 1'b1);
        @(negedge clk);
        drive_tx(0, 8'h5A, 1'b0);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_uart", 32'(tx_a), 32'd1);
        chk("midrst_tx_ready", 32'(tx_ready_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tx_check(txv[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_serial_core.md
# uart_serial_core

Parametrised UART transceiver for the serial front end: one RX deserialiser and one TX serialiser sharing a 16x-oversampling tick generator. It generalises the fixed 8N1 serial interface with configurable baud, data bits, parity and stop bits, plus error and overrun reporting. It sits between the UART pins and the RX/TX byte FIFOs: RX is a valid/ready source and TX is a valid/ready sink.

## Interface
- CLK_HZ, 100_000_000: core clock frequency.
- BAUD, 115200: line rate.
- DATA_BITS, 8: payload bits per frame, 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  core clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_uart  in  1  serial input, idle high, asynchronous to clk.
- rx_byte  out  DATA_BITS  received payload, LSB = first data bit.
- rx_valid  out  1  rx_byte holds an unconsumed frame.
- rx_ready  in  1  consumer accepts rx_byte.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_parity_err  out  1  one-cycle pulse: parity mismatch.
- rx_overrun  out  1  one-cycle pulse: good frame dropped because rx_valid was high.
- tx_uart  out  1  serial output, idle high.
- tx_byte  in  DATA_BITS  payload to send.
- tx_valid  in  1  tx_byte valid.
- tx_ready  out  1  serialiser idle and able to accept.

## Operation
- Tick generator: DIV = max(1, CLK_HZ / (BAUD*16)), integer floor. A free-running counter 0..DIV-1 asserts a one-cycle tick at DIV-1. One bit time = 16 ticks.
- RX input: passes through a two-flop synchroniser to rx_s, which resets to 1. Every RX decision uses rx_s.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when rx_s is seen low on a tick; the tick counter within the bit is cleared.
  - START: at the 8th tick, rx_s low -> DATA. rx_s high is a false start -> IDLE, with no flags.
  - DATA: sample every 16 ticks, shifting LSB-first. After DATA_BITS samples -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: one sample, compared against the odd or even parity of the payload.
  - STOP: one sample at mid-bit. Only the first stop bit is checked. Return to IDLE immediately after this sample; a second stop bit needs no wait.
- RX frame outcome:
  - Stop sampled low: pulse rx_frame_err and discard the frame. A frame error takes precedence; parity is not reported in that case.
  - Parity mismatch with a good stop bit: pulse rx_parity_err and discard the frame.
  - Good frame with rx_valid low: load rx_byte and set rx_valid.
  - Good frame with rx_valid high: pulse rx_overrun. The held rx_byte is kept unchanged.
- RX handshake: rx_valid stays high, and rx_byte stays stable, until a cycle with rx_valid && rx_ready. That cycle is the transfer. If a new frame completes in the same cycle as the transfer, the new byte loads and rx_valid stays high; no overrun is flagged.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE.
  - On tx_valid && tx_ready: latch tx_byte and compute parity. tx_ready falls the next cycle.
  - START is driven from the next tick. The sequence is start(0), DATA_BITS LSB-first, the parity bit if enabled, then STOP_BITS stop bits (1). Each bit lasts exactly 16 ticks.
  - After the last stop bit completes -> IDLE, with tx_ready = 1 on the following cycle.
- The RX and TX paths are fully independent and may run simultaneously. Only the tick generator is shared.

## Timing
- Reset values:
  - tx_uart = 1, tx_ready = 1.
  - rx_valid = 0, rx_byte = 0.
  - All error pulses = 0.
  - Both FSMs in IDLE, tick counter = 0.
- Reset asserted mid-frame:
  - TX: tx_uart returns to 1 at once and the frame is aborted.
  - RX: the partial frame is discarded and no flags are raised.
  - After release, the first start edge is accepted normally.
- TX latency from acceptance to the start-bit edge is 1 to DIV+1 cycles (waits for the next tick).
- Frame length in ticks: 16 × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS).
- RX latency from the synchronised start edge to rx_valid: ≈16 × (0.5 + DATA_BITS + (PARITY != 0) + 1) ticks, plus 2 synchroniser cycles. Tolerance is ±1 tick.
- Error pulses are asserted in the cycle after the stop-bit sample, for exactly one cycle.
- Back-to-back TX: with tx_valid held high, the next start bit follows the last stop bit within DIV+2 cycles.

## Test plan
- TX 8N1: CLK_HZ = 1_600_000, BAUD = 100_000 (DIV = 1). Send 0xA5 -> tx_uart = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_ready is low throughout the frame and high again after it.
- Loopback, 8E2: connect tx_uart to rx_uart and send 0x00, 0xFF, 0x3C with rx_ready = 1 -> the same three bytes on rx_byte with no error pulses; the parity bits on the line are 0, 0, 0.
- Errors, 8O1: drive a frame with a bad parity bit -> one rx_parity_err pulse and no rx_valid. Drive a frame with the stop bit = 0 -> one rx_frame_err pulse only.
- Overrun: hold rx_ready = 0 and receive 0x11 then 0x22 -> rx_byte = 0x11, and one rx_overrun pulse when 0x22 completes. Raising rx_ready then transfers 0x11 and rx_valid falls.
- Glitch and reset: drive a 4-cycle low pulse on rx_uart -> no valid and no error (false start). Assert rst_n low mid-TX frame -> tx_uart = 1 and tx_ready = 1 immediately; a new frame after release is correct.
- 7-bit mode: DATA_BITS = 7, PARITY = 0. Send 0x7F -> a 9-bit frame of 144 ticks; loopback returns 0x7F.
